output_deskew_controller: RTL
=============================

// Module: output_deskew_controller
// PURPOSE
//  Realigns the staggered result wavefront leaving the systolic array: column k emerges k cycles after column 0,
//  so channel k is delayed by (ARRAY_SIZE-1-k) cycles. Emits whole aligned rows with valid/last framing.
//  Sits between the array's bottom edge and the result writeback path.
// PARAMETERS
//  ARRAY_SIZE  32  number of columns/channels (>=1)
//  DATA_WIDTH  32  per-channel result width (FP32 accumulator)
//  FIFO_DEPTH  4   output row FIFO depth, power of 2 >=2 (used only with OUT_DESKEW_FIFO_EN)
// PORTS
//  clk        in   1                      clock
//  rst_n      in   1                      reset, asynchronous, active-low
//  flush      in   1                      synchronous clear of all state
//  tile_rows  in   16                     rows per tile; quasi-static while busy; 0 treated as 1
//  in_valid   in   1                      row wavefront starts this cycle (channel 0 data valid)
//  in_ready   out  1                      row start may be accepted
//  data_in    in   DATA_WIDTH x ARRAY_SIZE skewed results; channel k valid k cycles after in_valid
//  out_valid  out  1                      aligned row available
//  out_ready  in   1                      consumer accepts row
//  data_out   out  DATA_WIDTH x ARRAY_SIZE aligned row
//  out_last   out  1                      row is the final row of the tile
//  busy       out  1                      rows in flight or buffered
//  overflow   out  1                      sticky: in_valid while !in_ready (row dropped)
// BEHAVIOUR
//  - Reset/flush: all delay regs, valid pipe, row counter, FIFO, overflow -> 0; out_valid=0, data_out=0, out_last=0, busy=0.
//  - flush has priority over in_valid in the same cycle; that row is discarded, no overflow set.
//  - Channel k: (ARRAY_SIZE-1-k) delay regs, then one common output register. A valid bit travels a parallel
//    ARRAY_SIZE-1 stage pipe, so the row is complete at the output register.
//  - Latency: in_valid at cycle t -> row at output stage cycle t+ARRAY_SIZE; channel N-1 sampled at t+N-1.
//  - ARRAY_SIZE=1: no delay regs; latency 1 cycle.
//  - Back-to-back in_valid every cycle fully supported (one row/cycle throughput).
//  - Row counter increments on each row leaving the output stage; out_last=1 when counter==tile_rows-1,
//    then counter wraps to 0. Counter reflects rows presented to consumer (post-FIFO when FIFO built in).
//  - Data lanes of channels not yet valid are don't-care internally; data_out is zero whenever out_valid=0.
//  - overflow set by in_valid && !in_ready && !flush; cleared only by reset/flush.
//  - busy = |valid_pipe | out_valid | (fifo not empty).
// CONFIGURATION
//  OUT_DESKEW_FIFO_EN defined: FIFO_DEPTH-row FIFO after the output stage; out_valid=FIFO not empty;
//    pop on out_valid&&out_ready; FIFO holds out_last with data. Array cannot stall, so credit check:
//    in_ready = (fifo_count + inflight) < FIFO_DEPTH, inflight = rows accepted not yet pushed.
//    Push and pop in same cycle when full is legal (occupancy unchanged).
//  Not defined: no FIFO; in_ready tied 1; out_ready ignored; out_valid is the output-stage valid,
//    one-cycle pulse per row; overflow never sets.
// STRUCTURE
//  Shared matmul package: ARRAY_SIZE/DATA_WIDTH defaults, acc_t typedef (logic [DATA_WIDTH-1:0]),
//    row_t typedef (acc_t [ARRAY_SIZE]).
//  Sub-module deskew_delay_line #(DEPTH, DATA_WIDTH): per-channel shift register with flush,
//    DEPTH=0 is a pass-through; instantiated per channel in a generate loop.
// TESTING
//  1. ARRAY_SIZE=4, single row, channel k = 0x10+k driven at t+k -> out_valid at t+4, data_out={10,11,12,13},
//     out_last=1 with tile_rows=1.
//  2. 8 back-to-back rows, tile_rows=4 -> 8 consecutive out_valid cycles, out_last on rows 3 and 7, order kept.
//  3. flush asserted 2 cycles after in_valid -> no out_valid ever, busy=0 next cycle; following row aligned normally.
//  4. Async reset mid-stream -> all outputs 0 immediately; no stale row appears after release.
//  5. FIFO_EN, FIFO_DEPTH=4, out_ready=0, 6 back-to-back in_valid -> in_ready drops after 4 accepted,
//     overflow=1, then out_ready=1 drains exactly 4 rows in order.
//  6. ARRAY_SIZE=1, in_valid with 0xABCD -> out_valid next cycle, data_out=0xABCD.

Source files
------------

// File: rtl/output_deskew_controller_pkg.sv
// Shared matmul result-path definitions: default array geometry, accumulator/row types,
// and the tile-row helper used by the output deskew controller.
// Latency: n/a (package). Backpressure: n/a.
package output_deskew_controller_pkg;

   // Default systolic array geometry (FP32 accumulators, 32 columns).
   localparam int DEF_ARRAY_SIZE = 32;
   localparam int DEF_DATA_WIDTH = 32;

   // Width of the tile_rows input and of the output row counter.
   localparam int ROW_CNT_W = 16;

   typedef logic [DEF_DATA_WIDTH-1:0] acc_t;
   typedef acc_t [DEF_ARRAY_SIZE-1:0] row_t;

   // Index of the final row of a tile; a tile_rows value of 0 behaves as a one-row tile.
   function automatic logic [ROW_CNT_W-1:0] last_row_idx(input logic [ROW_CNT_W-1:0] tile_rows);
      return (tile_rows == '0) ? '0 : (tile_rows - 16'd1);
   endfunction

endpackage

// File: rtl/deskew_delay_line.sv
// Per-channel deskew shift register: delays one result lane by DEPTH cycles.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass-through).
// Backpressure: none; shifts every cycle, flush/reset clear all stages.
// Ports: clk, rst_n (async, active-low), flush (sync clear), din -> dout.
module deskew_delay_line
   import output_deskew_controller_pkg::*;
#(
   parameter int DEPTH      = 0,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         // Last column needs no delay; clock/reset/flush are intentionally unused here.
         logic w_unused;
         assign w_unused = clk ^ rst_n ^ flush;
         assign dout     = din;
      end else begin : g_shift
         logic [DATA_WIDTH-1:0] r_stage [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            end else if (flush) begin
               for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            end else begin
               r_stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
         end

         assign dout = r_stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with valid/ready on both sides and an occupancy count.
// Latency: 1 cycle from push to rd_vld. Backpressure: wr_rdy low only when full and not popping;
// a push and a pop in the same cycle while full is accepted (occupancy unchanged).
// Ports: clk, rst_n (async, active-low), flush (sync clear), wr_vld/wr_rdy/wr_dat,
//        rd_vld/rd_rdy/rd_dat, count (current occupancy). DEPTH must be a power of 2 >= 2.
module sync_fifo
   import output_deskew_controller_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   wr_vld,
   output logic                   wr_rdy,
   input  logic [WIDTH-1:0]       wr_dat,
   output logic                   rd_vld,
   input  logic                   rd_rdy,
   output logic [WIDTH-1:0]       rd_dat,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign rd_vld = (r_count != '0);
   assign wr_rdy = (r_count != (AW+1)'(DEPTH)) || rd_rdy;
   assign w_push = wr_vld && wr_rdy;
   assign w_pop  = rd_vld && rd_rdy;
   assign rd_dat = r_mem[r_rd_ptr];
   assign count  = r_count;

   // Storage needs no reset: entries are only read once the count says they were written.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/output_deskew_controller.sv
// Realigns the staggered systolic-array result wavefront into whole rows with valid/last framing.
// Latency: ARRAY_SIZE cycles from in_valid to the output stage (+1 through the optional row FIFO).
// Backpressure: none by default (out_ready ignored); with OUT_DESKEW_FIFO_EN a credit check on
//   in_ready protects the FIFO, and a row offered while !in_ready is dropped and flags overflow.
// Ports: clk, rst_n (async, active-low), flush (sync clear), tile_rows (rows per tile, 0 => 1),
//   in_valid/in_ready/data_in (skewed: channel k valid k cycles after in_valid),
//   out_valid/out_ready/data_out/out_last (aligned row), busy, overflow (sticky drop flag).
// Optional feature macro: OUT_DESKEW_FIFO_EN adds a FIFO_DEPTH-row output FIFO.
module output_deskew_controller
   import output_deskew_controller_pkg::*;
#(
   parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic [ROW_CNT_W-1:0]             tile_rows,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] data_in,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH*ARRAY_SIZE-1:0] data_out,
   output logic                             out_last,
   output logic                             busy,
   output logic                             overflow
);

   localparam int ROW_W = DATA_WIDTH * ARRAY_SIZE;

   logic                 w_accept;
   logic [ROW_W-1:0]     w_aligned;
   logic                 w_stage_in_vld;
   logic                 w_pipe_any;
   logic                 r_stage_vld;
   logic [ROW_W-1:0]     r_stage_dat;
   logic [ROW_CNT_W-1:0] r_row_cnt;
   logic                 w_row_leave;
   logic                 w_at_last;
   logic                 r_overflow;

   // flush wins over a row start in the same cycle: the row is simply never tracked.
   assign w_accept = in_valid && in_ready && !flush;

   // Channel k arrives k cycles late, so it is held back ARRAY_SIZE-1-k cycles to line up
   // with channel 0 at the input of the common output register.
   genvar k;
   generate
      for (k = 0; k < ARRAY_SIZE; k++) begin : g_lane
         deskew_delay_line #(
            .DEPTH      (ARRAY_SIZE - 1 - k),
            .DATA_WIDTH (DATA_WIDTH)
         ) u_dly (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .din   (data_in[k*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (w_aligned[k*DATA_WIDTH +: DATA_WIDTH])
         );
      end
   endgenerate

   // Row-valid token travels alongside channel 0 so it reaches the output register with
   // the last (undelayed) channel.
   generate
      if (ARRAY_SIZE > 1) begin : g_vpipe
         logic [ARRAY_SIZE-2:0] r_vpipe;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vpipe <= '0;
            end else if (flush) begin
               r_vpipe <= '0;
            end else begin
               r_vpipe[0] <= w_accept;
               for (int i = 1; i < ARRAY_SIZE - 1; i++) r_vpipe[i] <= r_vpipe[i-1];
            end
         end

         assign w_stage_in_vld = r_vpipe[ARRAY_SIZE-2];
         assign w_pipe_any     = |r_vpipe;
      end else begin : g_novpipe
         assign w_stage_in_vld = w_accept;
         assign w_pipe_any     = 1'b0;
      end
   endgenerate

   // Output stage: lanes of channels not yet valid are garbage upstream, so the register
   // only captures data together with a valid token and otherwise holds zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage_vld <= 1'b0;
         r_stage_dat <= '0;
      end else if (flush) begin
         r_stage_vld <= 1'b0;
         r_stage_dat <= '0;
      end else begin
         r_stage_vld <= w_stage_in_vld;
         r_stage_dat <= w_stage_in_vld ? w_aligned : '0;
      end
   end

   // Row counter tracks rows handed to the consumer; out_last marks the tile's final row.
   assign w_at_last = (r_row_cnt == last_row_idx(tile_rows));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_cnt <= '0;
      end else if (flush) begin
         r_row_cnt <= '0;
      end else if (w_row_leave) begin
         r_row_cnt <= w_at_last ? '0 : (r_row_cnt + 16'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (flush) begin
         r_overflow <= 1'b0;
      end else if (in_valid && !in_ready) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;

`ifdef OUT_DESKEW_FIFO_EN
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [CW-1:0]    w_fifo_cnt;
   logic [CW-1:0]    r_inflight;
   logic             w_fifo_vld;
   logic [ROW_W-1:0] w_fifo_dat;
   logic             w_fifo_wr_rdy_unused;

   // The array cannot stall, so every accepted row must already own a FIFO slot:
   // rows still in the deskew pipe or output stage count against the free space.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= '0;
      end else if (flush) begin
         r_inflight <= '0;
      end else begin
         case ({w_accept, r_stage_vld})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign in_ready = ({1'b0, w_fifo_cnt} + {1'b0, r_inflight}) < (CW+1)'(FIFO_DEPTH);

   sync_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (FIFO_DEPTH)
   ) u_row_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .wr_vld (r_stage_vld),
      .wr_rdy (w_fifo_wr_rdy_unused),
      .wr_dat (r_stage_dat),
      .rd_vld (w_fifo_vld),
      .rd_rdy (out_ready),
      .rd_dat (w_fifo_dat),
      .count  (w_fifo_cnt)
   );

   assign out_valid   = w_fifo_vld;
   assign data_out    = w_fifo_vld ? w_fifo_dat : '0;
   assign w_row_leave = w_fifo_vld && out_ready;
   assign out_last    = w_fifo_vld && w_at_last;
   assign busy        = w_pipe_any || r_stage_vld || w_fifo_vld;
`else
   // No buffering: each row is a one-cycle pulse and the consumer must take it.
   logic w_unused;
   assign w_unused    = out_ready & (FIFO_DEPTH > 0);

   assign in_ready    = 1'b1;
   assign out_valid   = r_stage_vld;
   assign data_out    = r_stage_dat;
   assign w_row_leave = r_stage_vld;
   assign out_last    = r_stage_vld && w_at_last;
   assign busy        = w_pipe_any || r_stage_vld;
`endif

endmodule
